// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: widths, the canonical NOP, fetch FSM
// states and the IF/ID register layout that the ID stage also consumes.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    HOLD,
    DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } ifid_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory port: valid/ready request channel plus a valid-only
// response channel (at most one request outstanding).
interface fetch_unit_if;
  import riscv_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            rsp_valid;
  logic [31:0]     rsp_data;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output rsp_valid,
    output rsp_data
  );

endinterface

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: flush beats stall, stall holds a valid entry,
// otherwise it takes the offered instruction or becomes a NOP bubble.
module ifid_reg
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            stall,
  input  logic            load_valid,
  input  logic [XLEN-1:0] load_pc,
  input  logic [31:0]     load_instr,
  output ifid_t           ifid_o
);

  ifid_t ifid_q;
  ifid_t ifid_d;

  always_comb begin
    ifid_d = '{valid: 1'b0, pc: '0, instr: NOP_INSTR};
    if (flush) begin
      ifid_d = '{valid: 1'b0, pc: '0, instr: NOP_INSTR};
    end else if (stall && ifid_q.valid) begin
      ifid_d = ifid_q;
    end else if (load_valid) begin
      ifid_d = '{valid: 1'b1, pc: load_pc, instr: load_instr};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ifid_q <= '{valid: 1'b0, pc: '0, instr: NOP_INSTR};
    end else begin
      ifid_q <= ifid_d;
    end
  end

  assign ifid_o = ifid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: next-PC selection, single-outstanding imem
// handshake FSM with a one-entry skid buffer feeding the IF/ID register.
module fetch_unit
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
  output logic [XLEN-1:0] next_pc_out,
  fetch_unit_if.master    imem,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_stall,
  output logic            ifid_valid,
  output logic [XLEN-1:0] ifid_pc,
  output logic [31:0]     ifid_instr
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic [31:0]     skid_instr_q, skid_instr_d;

  logic            req_valid;
  logic            accept;
  logic            load_valid;
  logic [XLEN-1:0] load_pc;
  logic [31:0]     load_instr;
  ifid_t           ifid;

  logic            unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign req_valid      = (state_q == FETCH) && !redirect_valid && !rst;
  assign accept         = req_valid && imem.req_ready;
  assign imem.req_valid = req_valid;
  assign imem.req_addr  = pc_in;

  always_comb begin
    next_pc_out = pc_in;
    if (rst) begin
      next_pc_out = '0;
    end else if (redirect_valid) begin
      next_pc_out = {redirect_pc[XLEN-1:2], 2'b00};
    end else if (accept) begin
      next_pc_out = pc_in + XLEN'(4);
    end
  end

  // Responses seen while a redirect is pending are dropped; DRAIN swallows
  // the one still in flight so it never reaches IF/ID.
  always_comb begin
    state_d      = state_q;
    req_pc_d     = req_pc_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    load_valid   = 1'b0;
    load_pc      = req_pc_q;
    load_instr   = imem.rsp_data;
    case (state_q)
      FETCH: begin
        if (accept) begin
          state_d  = WAIT;
          req_pc_d = pc_in;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          state_d = imem.rsp_valid ? FETCH : DRAIN;
        end else if (imem.rsp_valid) begin
          if (!id_stall || !ifid.valid) begin
            load_valid = 1'b1;
            state_d    = FETCH;
          end else begin
            skid_pc_d    = req_pc_q;
            skid_instr_d = imem.rsp_data;
            state_d      = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          skid_pc_d    = '0;
          skid_instr_d = NOP_INSTR;
          state_d      = FETCH;
        end else if (!id_stall) begin
          load_valid   = 1'b1;
          load_pc      = skid_pc_q;
          load_instr   = skid_instr_q;
          skid_pc_d    = '0;
          skid_instr_d = NOP_INSTR;
          state_d      = FETCH;
        end
      end
      DRAIN: begin
        if (imem.rsp_valid) begin
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH;
      req_pc_q     <= '0;
      skid_pc_q    <= '0;
      skid_instr_q <= NOP_INSTR;
    end else begin
      state_q      <= state_d;
      req_pc_q     <= req_pc_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end

  ifid_reg u_ifid_reg (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .stall      (id_stall),
    .load_valid (load_valid),
    .load_pc    (load_pc),
    .load_instr (load_instr),
    .ifid_o     (ifid)
  );

  assign ifid_valid = ifid.valid;
  assign ifid_pc    = ifid.pc;
  assign ifid_instr = ifid.instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: inputs change 1ns after each
// rising edge, outputs are compared before the next edge.
module tb_fetch_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic [31:0] next_pc_out;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_stall;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;

  int checks = 0;
  int errors = 0;

  fetch_unit_if imem ();

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .pc_in          (pc_in),
    .next_pc_out    (next_pc_out),
    .imem           (imem),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_stall       (id_stall),
    .ifid_valid     (ifid_valid),
    .ifid_pc        (ifid_pc),
    .ifid_instr     (ifid_instr)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic r, input logic [31:0] pc, input logic rdy,
                               input logic rv, input logic [31:0] rd, input logic redir,
                               input logic [31:0] rpc, input logic stall);
    rst            = r;
    pc_in          = pc;
    imem.req_ready = rdy;
    imem.rsp_valid = rv;
    imem.rsp_data  = rd;
    redirect_valid = redir;
    redirect_pc    = rpc;
    id_stall       = stall;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset
    applyStimulus(1, 32'h0, 1, 0, 32'h0, 0, 32'h0, 0);
    tick();
    checkOutput("rst_ifid_valid", 32'(ifid_valid), 32'h0);
    checkOutput("rst_ifid_pc", ifid_pc, 32'h0);
    checkOutput("rst_ifid_instr", ifid_instr, NOP_INSTR);
    checkOutput("rst_next_pc", next_pc_out, 32'h0);
    checkOutput("rst_req_valid", 32'(imem.req_valid), 32'h0);

    // Zero-wait memory streaming: 0, 4, 8
    applyStimulus(0, 32'h0, 1, 0, 32'h0, 0, 32'h0, 0);
    checkOutput("s0_req_valid", 32'(imem.req_valid), 32'h1);
    checkOutput("s0_req_addr", imem.req_addr, 32'h0);
    checkOutput("s0_next_pc", next_pc_out, 32'h4);
    tick();
    applyStimulus(0, 32'h4, 1, 1, 32'h00A0_0093, 0, 32'h0, 0);
    checkOutput("s0w_req_valid", 32'(imem.req_valid), 32'h0);
    checkOutput("s0w_next_pc", next_pc_out, 32'h4);
    tick();
    checkOutput("s0_ifid_valid", 32'(ifid_valid), 32'h1);
    checkOutput("s0_ifid_pc", ifid_pc, 32'h0);
    checkOutput("s0_ifid_instr", ifid_instr, 32'h00A0_0093);
    applyStimulus(0, 32'h4, 1, 0, 32'h0, 0, 32'h0, 0);
    checkOutput("s1_next_pc", next_pc_out, 32'h8);
    tick();
    checkOutput("s1_bubble_valid", 32'(ifid_valid), 32'h0);
    checkOutput("s1_bubble_instr", ifid_instr, NOP_INSTR);
    applyStimulus(0, 32'h8, 1, 1, 32'h00A0_0093, 0, 32'h0, 0);
    checkOutput("s1w_next_pc", next_pc_out, 32'h8);
    tick();
    checkOutput("s1_ifid_pc", ifid_pc, 32'h4);
    applyStimulus(0, 32'h8, 1, 0, 32'h0, 0, 32'h0, 0);
    checkOutput("s2_next_pc", next_pc_out, 32'hC);
    tick();
    applyStimulus(0, 32'hC, 1, 1, 32'h00A0_0093, 0, 32'h0, 0);
    tick();
    checkOutput("s2_ifid_valid", 32'(ifid_valid), 32'h1);
    checkOutput("s2_ifid_pc", ifid_pc, 32'h8);

    // Memory not ready for three cycles at 0x10
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 32'h10, 0, 0, 32'h0, 0, 32'h0, 0);
      checkOutput("nr_next_pc", next_pc_out, 32'h10);
      checkOutput("nr_req_valid", 32'(imem.req_valid), 32'h1);
      tick();
    end
    applyStimulus(0, 32'h10, 1, 0, 32'h0, 0, 32'h0, 0);
    checkOutput("nr_accept_next_pc", next_pc_out, 32'h14);
    tick();
    applyStimulus(0, 32'h14, 1, 1, 32'h0010_0113, 0, 32'h0, 0);
    tick();
    checkOutput("nr_ifid_pc", ifid_pc, 32'h10);
    checkOutput("nr_ifid_instr", ifid_instr, 32'h0010_0113);

    // Response under stall goes to the skid buffer
    applyStimulus(0, 32'h20, 1, 0, 32'h0, 0, 32'h0, 1);
    checkOutput("sk_next_pc", next_pc_out, 32'h24);
    tick();
    checkOutput("sk_hold1_pc", ifid_pc, 32'h10);
    applyStimulus(0, 32'h24, 1, 1, 32'h0000_0013, 0, 32'h0, 1);
    tick();
    checkOutput("sk_hold2_valid", 32'(ifid_valid), 32'h1);
    checkOutput("sk_hold2_pc", ifid_pc, 32'h10);
    checkOutput("sk_hold2_instr", ifid_instr, 32'h0010_0113);
    applyStimulus(0, 32'h24, 1, 0, 32'h0, 0, 32'h0, 1);
    checkOutput("sk_hold_req_valid", 32'(imem.req_valid), 32'h0);
    checkOutput("sk_hold_next_pc", next_pc_out, 32'h24);
    tick();
    checkOutput("sk_held_pc", ifid_pc, 32'h10);
    applyStimulus(0, 32'h24, 1, 0, 32'h0, 0, 32'h0, 0);
    tick();
    checkOutput("sk_out_valid", 32'(ifid_valid), 32'h1);
    checkOutput("sk_out_pc", ifid_pc, 32'h20);
    checkOutput("sk_out_instr", ifid_instr, 32'h0000_0013);

    // Redirect in WAIT with a late response
    applyStimulus(0, 32'h24, 1, 0, 32'h0, 0, 32'h0, 0);
    tick();
    applyStimulus(0, 32'h28, 1, 0, 32'h0, 1, 32'h103, 0);
    checkOutput("rd_next_pc", next_pc_out, 32'h100);
    checkOutput("rd_req_valid", 32'(imem.req_valid), 32'h0);
    tick();
    checkOutput("rd_bubble", 32'(ifid_valid), 32'h0);
    applyStimulus(0, 32'h100, 1, 0, 32'h0, 0, 32'h0, 0);
    checkOutput("rd_drain_req_valid", 32'(imem.req_valid), 32'h0);
    checkOutput("rd_drain_next_pc", next_pc_out, 32'h100);
    tick();
    applyStimulus(0, 32'h100, 1, 1, 32'hDEAD_BEEF, 0, 32'h0, 0);
    tick();
    checkOutput("rd_discard_valid", 32'(ifid_valid), 32'h0);
    checkOutput("rd_discard_instr", ifid_instr, NOP_INSTR);
    applyStimulus(0, 32'h100, 1, 0, 32'h0, 0, 32'h0, 0);
    checkOutput("rd_fetch_addr", imem.req_addr, 32'h100);
    checkOutput("rd_fetch_valid", 32'(imem.req_valid), 32'h1);
    checkOutput("rd_fetch_next_pc", next_pc_out, 32'h104);
    tick();
    applyStimulus(0, 32'h104, 1, 1, 32'h00A0_0093, 0, 32'h0, 0);
    tick();
    checkOutput("rd_ifid_pc", ifid_pc, 32'h100);

    // Redirect coincident with response while stalled
    applyStimulus(0, 32'h104, 1, 0, 32'h0, 0, 32'h0, 1);
    tick();
    checkOutput("co_held_valid", 32'(ifid_valid), 32'h1);
    applyStimulus(0, 32'h108, 1, 1, 32'h1111_1111, 1, 32'h200, 1);
    checkOutput("co_next_pc", next_pc_out, 32'h200);
    tick();
    checkOutput("co_flush_valid", 32'(ifid_valid), 32'h0);
    checkOutput("co_flush_instr", ifid_instr, NOP_INSTR);

    // PC wrap at top of address space
    applyStimulus(0, 32'hFFFF_FFFC, 1, 0, 32'h0, 0, 32'h0, 0);
    checkOutput("wr_req_valid", 32'(imem.req_valid), 32'h1);
    checkOutput("wr_next_pc", next_pc_out, 32'h0);
    tick();

    // Reset while waiting for a response
    applyStimulus(1, 32'h0, 1, 1, 32'h2222_2222, 0, 32'h0, 0);
    checkOutput("rw_req_valid", 32'(imem.req_valid), 32'h0);
    checkOutput("rw_next_pc", next_pc_out, 32'h0);
    tick();
    checkOutput("rw_ifid_valid", 32'(ifid_valid), 32'h0);
    checkOutput("rw_ifid_instr", ifid_instr, NOP_INSTR);
    checkOutput("rw_ifid_pc", ifid_pc, 32'h0);
    applyStimulus(0, 32'h0, 0, 1, 32'h3333_3333, 0, 32'h0, 0);
    checkOutput("rw_fetch_req_valid", 32'(imem.req_valid), 32'h1);
    checkOutput("rw_fetch_next_pc", next_pc_out, 32'h0);
    tick();
    checkOutput("rw_stray_rsp_valid", 32'(ifid_valid), 32'h0);
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 0);
    checkOutput("rw_still_fetch", 32'(imem.req_valid), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
